sccb_arbiter: RTL and testbench

SCCB_ARBITER -- requirements
Module: sccb_arbiter

---
 rtl/sccb_arbiter_if.sv | 49 ++++
 rtl/sccb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sccb_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sccb_arbiter_if.sv
// rtl/sccb_arbiter_if.sv - requester/SCCB-master bundle for the two-port SCCB write arbiter
//
// Purpose: groups every signal between sccb_arbiter and its surroundings.
// The two requesters and the shared SCCB master sit on one side; the arbiter sits on the other.
// Port summary:
//   Requester side, into the arbiter:
//     req[1:0]              level write request; bit i belongs to requester i
//     chip_addr_in[15:0]    {req1, req0} chip address bytes
//     sub_addr_in[15:0]     {req1, req0} sub-address bytes
//     w_data_in[15:0]       {req1, req0} write data bytes
//   Requester side, out of the arbiter:
//     grant[1:0]            one-hot current owner
//     ack[1:0]              one-cycle write-complete pulse
//     err[1:0]              one-cycle write-timeout pulse
//   SCCB master side, out of the arbiter:
//     m_start               one-cycle start pulse
//     m_addr                chip address with the R/W bit forced to 0
//     m_subaddr             sub-address
//     m_w_data              write data
//   SCCB master side, into the arbiter:
//     m_done                transaction-complete pulse
//     m_busy                busy level
//   Modport master is the arbiter. Modport slave is the environment.

interface sccb_arbiter_if;
    logic [1:0]  req;
    logic [15:0] chip_addr_in;
    logic [15:0] sub_addr_in;
    logic [15:0] w_data_in;
    logic [1:0]  grant;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic        m_start;
    logic [7:0]  m_addr;
    logic [7:0]  m_subaddr;
    logic [7:0]  m_w_data;
    logic        m_done;
    logic        m_busy;

    modport master (
        input  req, chip_addr_in, sub_addr_in, w_data_in, m_done, m_busy,
        output grant, ack, err, m_start, m_addr, m_subaddr, m_w_data
    );

    modport slave (
        output req, chip_addr_in, sub_addr_in, w_data_in, m_done, m_busy,
        input  grant, ack, err, m_start, m_addr, m_subaddr, m_w_data
    );
endinterface

// File: rtl/sccb_arbiter.sv
// rtl/sccb_arbiter.sv - round-robin arbiter sharing one SCCB write master between two requesters
//
// Purpose: the arbiter picks one requester, latches that requester's bytes, and starts the master.
// It waits for m_done, acknowledges the winner, and then releases the bus.
// Optional macro SCCB_ARB_TIMEOUT_EN adds a WAIT timeout. The timeout length is TIMEOUT_CYCLES.
// On a timeout the arbiter pulses err to the winner.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    sccb_arbiter_if.master; see that file for the signal list

module sccb_arbiter #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic           clk,
    input  logic           reset,
    sccb_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        WAIT,
        RELEASE
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_winner;       // 0 = requester 0, 1 = requester 1
    logic       w_winner_nxt;
    logic       r_last;         // requester served most recently
    logic       w_last_nxt;
    logic [1:0] r_grant;
    logic [1:0] w_grant_nxt;
    logic [1:0] r_ack;
    logic [1:0] w_ack_nxt;
    logic       w_pick;
    logic       w_load;
    logic [7:0] r_m_addr;
    logic [7:0] r_m_subaddr;
    logic [7:0] r_m_w_data;
    logic [7:0] w_addr_sel;
    logic [7:0] w_sub_sel;
    logic [7:0] w_data_sel;

`ifdef SCCB_ARB_TIMEOUT_EN
    localparam logic [19:0] TO_LAST = TIMEOUT_CYCLES - 20'd1;
    logic [19:0] r_cnt;
    logic [1:0]  r_err;
    logic [1:0]  w_err_nxt;
`endif

    // Both requesters set: the one not served last wins. A lone request wins outright.
    always_comb begin
        w_pick = ~r_last;
        case (bus.req)
            2'b01:   w_pick = 1'b0;
            2'b10:   w_pick = 1'b1;
            default: w_pick = ~r_last;
        endcase
    end

    assign w_addr_sel = w_pick ? bus.chip_addr_in[15:8] : bus.chip_addr_in[7:0];
    assign w_sub_sel  = w_pick ? bus.sub_addr_in[15:8]  : bus.sub_addr_in[7:0];
    assign w_data_sel = w_pick ? bus.w_data_in[15:8]    : bus.w_data_in[7:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_winner_nxt = r_winner;
        w_last_nxt   = r_last;
        w_grant_nxt  = r_grant;
        w_ack_nxt    = 2'b00;
        w_load       = 1'b0;
`ifdef SCCB_ARB_TIMEOUT_EN
        w_err_nxt    = 2'b00;
`endif
        case (r_state)
            IDLE: begin
                if (bus.req != 2'b00 && !bus.m_busy)
                    w_state_nxt = ARB;
            end
            ARB: begin
                // A request that vanished before arbitration is dropped silently.
                if (bus.req == 2'b00) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_winner_nxt = w_pick;
                    w_grant_nxt  = w_pick ? 2'b10 : 2'b01;
                    w_load       = 1'b1;
                    w_state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // m_done takes priority over a timeout landing on the same cycle.
                if (bus.m_done) begin
                    w_ack_nxt   = r_winner ? 2'b10 : 2'b01;
                    w_state_nxt = RELEASE;
                end
`ifdef SCCB_ARB_TIMEOUT_EN
                else if (r_cnt == TO_LAST) begin
                    w_err_nxt   = r_winner ? 2'b10 : 2'b01;
                    w_state_nxt = RELEASE;
                end
`endif
            end
            RELEASE: begin
                w_grant_nxt = 2'b00;
                w_last_nxt  = r_winner;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_winner    <= 1'b0;
            r_last      <= 1'b1;
            r_grant     <= 2'b00;
            r_ack       <= 2'b00;
            r_m_addr    <= 8'h00;
            r_m_subaddr <= 8'h00;
            r_m_w_data  <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_winner <= w_winner_nxt;
            r_last   <= w_last_nxt;
            r_grant  <= w_grant_nxt;
            r_ack    <= w_ack_nxt;
            // The master bytes only change on an ARB win. They hold through the whole transaction.
            if (w_load) begin
                r_m_addr    <= w_addr_sel & 8'hFE;
                r_m_subaddr <= w_sub_sel;
                r_m_w_data  <= w_data_sel;
            end
        end
    end

`ifdef SCCB_ARB_TIMEOUT_EN
    // The counter reads 0 on the first WAIT cycle. It advances once per WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 20'd0;
            r_err <= 2'b00;
        end else begin
            r_err <= w_err_nxt;
            if (r_state == WAIT)
                r_cnt <= r_cnt + 20'd1;
            else
                r_cnt <= 20'd0;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 2'b00;
`endif

    assign bus.grant     = r_grant;
    assign bus.ack       = r_ack;
    assign bus.m_start   = (r_state == ISSUE);
    assign bus.m_addr    = r_m_addr;
    assign bus.m_subaddr = r_m_subaddr;
    assign bus.m_w_data  = r_m_w_data;

endmodule

// File: tb/tb_sccb_arbiter.sv
// tb/tb_sccb_arbiter.sv - directed self-checking bench for sccb_arbiter

module tb_sccb_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    sccb_arbiter_if bus ();

    sccb_arbiter #(.TIMEOUT_CYCLES(20'd100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for m_start with req already driven, then completes the write.
    task automatic do_txn(input string tag, input logic [1:0] exp_g, input logic [7:0] exp_addr,
                          input int done_delay);
        int n;
        n = 0;
        while (!bus.m_start && n < 20) begin
            step();
            n++;
        end
        check({tag, "_start"}, bus.m_start, 1);
        check({tag, "_grant"}, bus.grant, exp_g);
        check({tag, "_addr"}, bus.m_addr, exp_addr);
        step();
        repeat (done_delay) step();
        check({tag, "_noack_wait"}, bus.ack, 2'b00);
        bus.m_done = 1'b1;
        step();
        bus.m_done = 1'b0;
        check({tag, "_ack"}, bus.ack, exp_g);
        check({tag, "_err"}, bus.err, 2'b00);
        step();
        check({tag, "_ack_once"}, bus.ack, 2'b00);
        check({tag, "_grant_clr"}, bus.grant, 2'b00);
    endtask

    initial begin
        int n;
        int starts;
        n_checks = 0;
        n_fails = 0;
        reset = 1'b1;
        bus.req = 2'b00;
        bus.chip_addr_in = 16'h55CD;
        bus.sub_addr_in = 16'h3412;
        bus.w_data_in = 16'h7780;
        bus.m_done = 1'b0;
        bus.m_busy = 1'b0;

        // Reset state, sampled while reset is high
        step();
        step();
        check("rst_grant", bus.grant, 2'b00);
        check("rst_ack", bus.ack, 2'b00);
        check("rst_err", bus.err, 2'b00);
        check("rst_start", bus.m_start, 1'b0);
        check("rst_addr", bus.m_addr, 8'h00);
        check("rst_sub", bus.m_subaddr, 8'h00);
        check("rst_wdata", bus.m_w_data, 8'h00);
        reset = 1'b0;
        step();

        // Single write from requester 0, with the 2-cycle start latency
        bus.req = 2'b01;
        step();
        check("t1_lat_arb", bus.m_start, 1'b0);
        step();
        check("t1_lat_start", bus.m_start, 1'b1);
        check("t1_grant", bus.grant, 2'b01);
        check("t1_addr", bus.m_addr, 8'hCC);
        check("t1_sub", bus.m_subaddr, 8'h12);
        check("t1_wdata", bus.m_w_data, 8'h80);
        bus.chip_addr_in = 16'hFFFF;
        bus.sub_addr_in = 16'hFFFF;
        bus.w_data_in = 16'hFFFF;
        step();
        check("t1_start_once", bus.m_start, 1'b0);
        repeat (19) step();
        check("t1_addr_hold", bus.m_addr, 8'hCC);
        check("t1_sub_hold", bus.m_subaddr, 8'h12);
        check("t1_wdata_hold", bus.m_w_data, 8'h80);
        bus.m_done = 1'b1;
        bus.req = 2'b00;
        step();
        bus.m_done = 1'b0;
        check("t1_ack", bus.ack, 2'b01);
        check("t1_grant_hold", bus.grant, 2'b01);
        step();
        check("t1_ack_once", bus.ack, 2'b00);
        check("t1_grant_clr", bus.grant, 2'b00);

        // Both requesting: alternation. After t1, requester 0 was served last.
        // Fresh reset so requester 0 wins the first tie.
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.chip_addr_in = 16'h4321;
        bus.req = 2'b11;
        do_txn("rr0", 2'b01, 8'h20, 3);
        do_txn("rr1", 2'b10, 8'h42, 5);
        do_txn("rr2", 2'b01, 8'h20, 1);
        do_txn("rr3", 2'b10, 8'h42, 0);
        bus.req = 2'b00;
        repeat (3) step();

        // Master busy blocks issue. A stray m_done outside WAIT is ignored.
        bus.m_busy = 1'b1;
        bus.req = 2'b10;
        starts = 0;
        for (int i = 0; i < 50; i++) begin
            bus.m_done = (i == 10);
            step();
            if (bus.m_start || bus.ack != 2'b00 || bus.grant != 2'b00) starts++;
        end
        bus.m_done = 1'b0;
        check("busy_no_activity", starts, 0);
        bus.m_busy = 1'b0;
        do_txn("busy", 2'b10, 8'h42, 2);
        bus.req = 2'b00;
        repeat (2) step();

        // A one-cycle request pulse vanishes before ARB
        bus.req = 2'b01;
        step();
        bus.req = 2'b00;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.m_start || bus.grant != 2'b00) starts++;
        end
        check("pulse_dropped", starts, 0);

        // Reset in WAIT abandons the write, and the first tie afterwards goes to requester 0.
        // Serve requester 0 first, so that a lost last-served value would favour requester 1.
        bus.req = 2'b01;
        do_txn("pre0", 2'b01, 8'h20, 1);
        bus.req = 2'b11;
        n = 0;
        while (!bus.m_start && n < 20) begin
            step();
            n++;
        end
        check("pre1_grant", bus.grant, 2'b10);
        step();
        step();
        reset = 1'b1;
        #1;
        check("rstw_grant", bus.grant, 2'b00);
        step();
        check("rstw_ack", bus.ack, 2'b00);
        check("rstw_err", bus.err, 2'b00);
        reset = 1'b0;
        do_txn("post", 2'b01, 8'h20, 2);
        bus.req = 2'b00;
        repeat (2) step();

`ifdef SCCB_ARB_TIMEOUT_EN
        // Timeout: no m_done ever arrives
        bus.req = 2'b10;
        n = 0;
        while (!bus.m_start && n < 20) begin
            step();
            n++;
        end
        bus.req = 2'b00;
        step();
        n = 0;
        while (bus.err == 2'b00 && bus.ack == 2'b00 && n < 300) begin
            step();
            n++;
        end
        check("to_cycles", n, 100);
        check("to_err", bus.err, 2'b10);
        check("to_ack", bus.ack, 2'b00);
        step();
        check("to_err_once", bus.err, 2'b00);
        check("to_grant_clr", bus.grant, 2'b00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
